fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: boots the PC from a reset-vector word, fetches over a rd/ready
// handshake, and feeds {IR, PC, valid} to the FD register. Stalls park a late word in a skid register.
module fetch_stage #(
    parameter int                ADDR_W            = 20,
    parameter logic [ADDR_W-1:0] RESET_VECTOR_ADDR = '0,
    parameter logic [31:0]       NOP_WORD          = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       IR_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic              IR_valid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_p0, state_nxt;
    logic [ADDR_W-1:0] pc_p0, pc_nxt;
    logic [31:0]       skid_p0, skid_nxt;
    logic [31:0]       ir_nxt;
    logic [ADDR_W-1:0] pc_out_nxt;
    logic              vld_nxt;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    always_comb begin
        state_nxt  = state_p0;
        pc_nxt     = pc_p0;
        skid_nxt   = skid_p0;
        ir_nxt     = IR_out;
        pc_out_nxt = PC_out;
        vld_nxt    = IR_valid;
        imem_rd    = 1'b0;
        imem_addr  = pc_p0;

        case (state_p0)
            BOOT: begin
                imem_rd   = 1'b1;
                imem_addr = RESET_VECTOR_ADDR;
                if (imem_ready) begin
                    pc_nxt    = imem_rdata[ADDR_W-1:0];
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                imem_rd = 1'b1;
                // Redirect wins over everything; any word returning this cycle belongs to the dead path.
                if (redirect) begin
                    pc_nxt  = redirect_pc;
                    ir_nxt  = NOP_WORD;
                    vld_nxt = 1'b0;
                end else if (imem_ready && !stall) begin
                    ir_nxt     = imem_rdata;
                    pc_out_nxt = pc_p0;
                    vld_nxt    = 1'b1;
                    pc_nxt     = pc_inc(pc_p0);
                end else if (imem_ready) begin
                    skid_nxt  = imem_rdata;
                    state_nxt = HOLD;
                end else if (!stall) begin
                    ir_nxt     = NOP_WORD;
                    pc_out_nxt = pc_p0;
                    vld_nxt    = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    ir_nxt    = NOP_WORD;
                    vld_nxt   = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    ir_nxt     = skid_p0;
                    pc_out_nxt = pc_p0;
                    vld_nxt    = 1'b1;
                    pc_nxt     = pc_inc(pc_p0);
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // Stage boundary: fetch state and FD-register outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= BOOT;
            pc_p0    <= '0;
            skid_p0  <= '0;
            IR_out   <= NOP_WORD;
            PC_out   <= '0;
            IR_valid <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            skid_p0  <= skid_nxt;
            IR_out   <= ir_nxt;
            PC_out   <= pc_out_nxt;
            IR_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, wait states, stall skid, redirect, PC wrap, async reset.
module tb_fetch_stage;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready = 1'b1;
    logic [31:0]       IR_out;
    logic [ADDR_W-1:0] PC_out;
    logic              IR_valid;

    logic [31:0] mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    // Zero-wait memory indexed by the low address byte; readiness comes from imem_ready.
    assign imem_rdata = mem[imem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W(ADDR_W),
        .RESET_VECTOR_ADDR(20'h0),
        .NOP_WORD(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_rd(imem_rd),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .IR_out(IR_out),
        .PC_out(PC_out),
        .IR_valid(IR_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reboot();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        imem_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h0, 20'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got IR=%h PC=%h v=%b want 0/0/0", IR_out, PC_out, IR_valid);
        end
        vectors++;
        if ({imem_rd, imem_addr} !== {1'b1, 20'h0}) begin
            miscompares++;
            $display("FAIL reset_req: got rd=%b addr=%h want 1/00000", imem_rd, imem_addr);
        end
    endtask

    task automatic test_boot();
        tick();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 20'h40;
        imem_ready = 1'b1;
        reset = 1'b0;
        tick();
        vectors++;
        if ({imem_rd, imem_addr, IR_valid} !== {1'b1, 20'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL boot_pc: got rd=%b addr=%h v=%b want 1/00010/0", imem_rd, imem_addr, IR_valid);
        end
        stall = 1'b0;
        redirect = 1'b0;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid, imem_addr} !== {32'hABCD, 20'h10, 1'b1, 20'h11}) begin
            miscompares++;
            $display("FAIL boot_first: got IR=%h PC=%h v=%b addr=%h want 0000abcd/00010/1/00011",
                     IR_out, PC_out, IR_valid, imem_addr);
        end
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h1234, 20'h11, 1'b1}) begin
            miscompares++;
            $display("FAIL boot_second: got IR=%h PC=%h v=%b want 00001234/00011/1", IR_out, PC_out, IR_valid);
        end
    endtask

    task automatic test_wait_states();
        reboot();
        tick();
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({IR_out, IR_valid, imem_rd, imem_addr} !== {32'h0, 1'b0, 1'b1, 20'h11}) begin
                miscompares++;
                $display("FAIL wait_cycle%0d: got IR=%h v=%b rd=%b addr=%h want 0/0/1/00011",
                         i, IR_out, IR_valid, imem_rd, imem_addr);
            end
        end
        imem_ready = 1'b1;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h1234, 20'h11, 1'b1}) begin
            miscompares++;
            $display("FAIL wait_done: got IR=%h PC=%h v=%b want 00001234/00011/1", IR_out, PC_out, IR_valid);
        end
    endtask

    task automatic test_stall_skid();
        reboot();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({IR_out, PC_out, IR_valid, imem_rd} !== {32'hABCD, 20'h10, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got IR=%h PC=%h v=%b rd=%b want 0000abcd/00010/1/0",
                         i, IR_out, PC_out, IR_valid, imem_rd);
            end
        end
        stall = 1'b0;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid, imem_rd, imem_addr} !== {32'h1234, 20'h11, 1'b1, 1'b1, 20'h12}) begin
            miscompares++;
            $display("FAIL stall_release: got IR=%h PC=%h v=%b rd=%b addr=%h want 00001234/00011/1/1/00012",
                     IR_out, PC_out, IR_valid, imem_rd, imem_addr);
        end
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h2222, 20'h12, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_next: got IR=%h PC=%h v=%b want 00002222/00012/1", IR_out, PC_out, IR_valid);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 20'h40;
        tick();
        vectors++;
        if ({IR_out, IR_valid, imem_addr} !== {32'h0, 1'b0, 20'h40}) begin
            miscompares++;
            $display("FAIL redirect_bubble: got IR=%h v=%b addr=%h want 0/0/00040", IR_out, IR_valid, imem_addr);
        end
        stall = 1'b0;
        redirect = 1'b0;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h1598, 20'h40, 1'b1}) begin
            miscompares++;
            $display("FAIL redirect_target: got IR=%h PC=%h v=%b want 00001598/00040/1", IR_out, PC_out, IR_valid);
        end
        stall = 1'b1;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid, imem_rd} !== {32'h1598, 20'h40, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_enter: got IR=%h PC=%h v=%b rd=%b want 00001598/00040/1/0",
                     IR_out, PC_out, IR_valid, imem_rd);
        end
        redirect = 1'b1;
        redirect_pc = 20'h10;
        tick();
        vectors++;
        if ({IR_out, IR_valid, imem_rd, imem_addr} !== {32'h0, 1'b0, 1'b1, 20'h10}) begin
            miscompares++;
            $display("FAIL hold_redirect: got IR=%h v=%b rd=%b addr=%h want 0/0/1/00010",
                     IR_out, IR_valid, imem_rd, imem_addr);
        end
        redirect = 1'b0;
        stall = 1'b0;
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'hABCD, 20'h10, 1'b1}) begin
            miscompares++;
            $display("FAIL hold_redirect_target: got IR=%h PC=%h v=%b want 0000abcd/00010/1",
                     IR_out, PC_out, IR_valid);
        end
    endtask

    task automatic test_wrap();
        mem[0] = 32'h000F_FFFF;
        reboot();
        tick();
        vectors++;
        if (imem_addr !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL wrap_boot: got addr=%h want fffff", imem_addr);
        end
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid, imem_addr} !== {32'hFEED, 20'hFFFFF, 1'b1, 20'h0}) begin
            miscompares++;
            $display("FAIL wrap_pc: got IR=%h PC=%h v=%b addr=%h want 0000feed/fffff/1/00000",
                     IR_out, PC_out, IR_valid, imem_addr);
        end
        mem[0] = 32'h0000_0010;
    endtask

    task automatic test_async_reset();
        reboot();
        tick();
        tick();
        stall = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({IR_out, PC_out, IR_valid, imem_rd, imem_addr} !== {32'h0, 20'h0, 1'b0, 1'b1, 20'h0}) begin
            miscompares++;
            $display("FAIL async_reset: got IR=%h PC=%h v=%b rd=%b addr=%h want 0/0/0/1/00000",
                     IR_out, PC_out, IR_valid, imem_rd, imem_addr);
        end
        tick();
        reset = 1'b0;
        stall = 1'b0;
        tick();
        vectors++;
        if (imem_addr !== 20'h10) begin
            miscompares++;
            $display("FAIL reboot_pc: got addr=%h want 00010", imem_addr);
        end
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'hABCD, 20'h10, 1'b1}) begin
            miscompares++;
            $display("FAIL reboot_first: got IR=%h PC=%h v=%b want 0000abcd/00010/1", IR_out, PC_out, IR_valid);
        end
        tick();
        vectors++;
        if ({IR_out, PC_out, IR_valid} !== {32'h1234, 20'h11, 1'b1}) begin
            miscompares++;
            $display("FAIL reboot_second: got IR=%h PC=%h v=%b want 00001234/00011/1", IR_out, PC_out, IR_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[8'h00] = 32'h0000_0010;
        mem[8'h10] = 32'h0000_ABCD;
        mem[8'h11] = 32'h0000_1234;
        mem[8'h12] = 32'h0000_2222;
        mem[8'h40] = 32'h0000_1598;
        mem[8'hFF] = 32'h0000_FEED;

        test_reset();
        test_boot();
        test_wait_states();
        test_stall_skid();
        test_redirect();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
